// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver: segment encoding
// and leading-zero blank mask generation.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Bit k set when digit k is a leading zero; digit 0 always stays lit.
  function automatic logic [7:0] lz_mask(input logic [31:0] value, input int n);
    logic [7:0] m;
    logic       seen_nz;
    m       = '0;
    seen_nz = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        if (value[4*k +: 4] != 4'h0) seen_nz = 1'b1;
        else if (k != 0 && !seen_nz) m[k] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for the scan driver: load strobe, digit data and masks in,
// display pin drive out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lzb_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_tick;

  modport master (
    output load, value_in, blank_mask, lzb_en, blink_mask,
    input  seg_out, an_out, frame_tick
  );

  modport slave (
    input  load, value_in, blank_mask, lzb_en, blink_mask,
    output seg_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_prescaler.sv
// Free-running divider: tick is high for one clk out of every DIV.
module seg7_scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous updates,
// per-digit and leading-zero blanking. Define DISP_BLINK_EN to enable digit blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    tick;
  logic                    wrap;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;
  logic                    pend_valid;
  logic [NUM_DIGITS-1:0]   lz_vec, blink_vec, blank_vec;
  logic [7:0]              lz_full;
  logic [3:0]              nibble;
  logic [6:0]              seg_p0, seg_p1;
  logic [NUM_DIGITS-1:0]   an_p0, an_p1;

  seg7_scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign wrap = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    digit_idx <= '0;
    else if (tick) digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
  end

  // A load coinciding with the wrap bypasses pending so it shows this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_blank <= '0;
    end else if (wrap) begin
      pend_valid <= 1'b0;
      if (bus.load) begin
        disp_val   <= bus.value_in;
        disp_blank <= bus.blank_mask;
      end else if (pend_valid) begin
        disp_val   <= pend_val;
        disp_blank <= pend_blank;
      end
    end else if (bus.load) begin
      pend_val   <= bus.value_in;
      pend_blank <= bus.blank_mask;
      pend_valid <= 1'b1;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BC_W-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  assign blink_vec = blink_phase ? bus.blink_mask : '0;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^bus.blink_mask;
  assign blink_vec         = '0;
`endif

  // Stage p0: glyph and anode selection for the digit currently indexed.
  always_comb begin
    lz_full   = lz_mask(32'(disp_val), NUM_DIGITS);
    lz_vec    = bus.lzb_en ? lz_full[NUM_DIGITS-1:0] : '0;
    blank_vec = disp_blank | lz_vec | blink_vec;
    nibble    = disp_val[{digit_idx, 2'b00} +: 4];
    seg_p0    = blank_vec[digit_idx] ? SEG_BLANK : hex_to_seg(nibble);
    an_p0     = ~(NUM_DIGITS'(1) << digit_idx);
  end

  // Stage p1: registered pin drive, segments and anode switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= '1;
    end else begin
      seg_p1 <= seg_p0;
      an_p1  <= an_p0;
    end
  end

  assign bus.seg_out    = seg_p1;
  assign bus.an_out     = an_p1;
  assign bus.frame_tick = wrap;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a frame-level reference model.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FR = N * SD;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: n counts clock edges since reset release; content changes only at frame ends.
  int          n, wraps, md;
  logic [15:0] sh_v, pd_v;
  logic [3:0]  sh_b, pd_b;
  bit          pd_ok, mblk;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_ft;

  assign exp_ft = rst_n && ((n % FR) == FR - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; wraps = 0; sh_v = '0; pd_v = '0; sh_b = '0; pd_b = '0; pd_ok = 0;
      exp_seg = 7'h7F; exp_an = 4'hF;
    end else begin
      md   = (n / SD) % N;
      mblk = sh_b[md] || (bus.lzb_en && md != 0 && (sh_v >> (4 * md)) == 16'd0);
`ifdef DISP_BLINK_EN
      if (((wraps / BD) % 2) == 1 && bus.blink_mask[md]) mblk = 1;
`endif
      exp_seg = mblk ? 7'h7F : SEG_TAB[sh_v[4*md +: 4]];
      exp_an  = ~(4'b0001 << md);
      if ((n % FR) == FR - 1) begin
        if (bus.load) begin sh_v = bus.value_in; sh_b = bus.blank_mask; end
        else if (pd_ok) begin sh_v = pd_v; sh_b = pd_b; end
        pd_ok = 0;
        wraps++;
      end else if (bus.load) begin
        pd_v = bus.value_in; pd_b = bus.blank_mask; pd_ok = 1;
      end
      n++;
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] bm);
    bus.value_in   = v;
    bus.blank_mask = bm;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Returns at the negedge where frame_tick is high.
  task automatic wait_wrap();
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL wait_wrap: frame_tick not seen within %0d cycles, required 1", 3 * FR);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load = 0; bus.value_in = '0; bus.blank_mask = '0; bus.lzb_en = 0; bus.blink_mask = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.seg_out !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %h want 7f", bus.seg_out); end
    tests_run++;
    if (bus.an_out !== 4'hF) begin tests_failed++; $display("FAIL reset_an: got %h want f", bus.an_out); end
    tests_run++;
    if (bus.frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_ft: got %b want 0", bus.frame_tick); end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.an_out !== ~(4'b0001 << ((i / SD) % N)) || bus.frame_tick !== ((i % FR) == FR - 2) ||
          bus.seg_out !== 7'h40) begin
        tests_failed++;
        $display("FAIL scan_seq i=%0d: an=%h ft=%b seg=%h want an=%h ft=%b seg=40", i, bus.an_out,
                 bus.frame_tick, bus.seg_out, ~(4'b0001 << ((i / SD) % N)), ((i % FR) == FR - 2));
      end
    end
  endtask

  task automatic test_frame_update();
    logic [6:0] want [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    wait_wrap();
    repeat (5) @(negedge clk);
    do_load(16'h12AF, 4'h0);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== exp_seg || bus.an_out !== exp_an || bus.frame_tick !== exp_ft) begin
        tests_failed++;
        $display("FAIL mid_frame_hold: seg=%h an=%h ft=%b want %h %h %b", bus.seg_out, bus.an_out,
                 bus.frame_tick, exp_seg, exp_an, exp_ft);
      end
      if (bus.frame_tick === 1'b1) break;
    end
    @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== want[i / SD] || bus.an_out !== ~(4'b0001 << (i / SD))) begin
        tests_failed++;
        $display("FAIL val_12AF i=%0d: seg=%h an=%h want %h %h", i, bus.seg_out, bus.an_out,
                 want[i / SD], ~(4'b0001 << (i / SD)));
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] want_a [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [6:0] want_b [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    bus.lzb_en = 1'b1;
    do_load(16'h0050, 4'h0);
    wait_wrap();
    @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== want_a[i / SD] || bus.an_out !== ~(4'b0001 << (i / SD))) begin
        tests_failed++;
        $display("FAIL lzb_0050 i=%0d: seg=%h an=%h want %h %h", i, bus.seg_out, bus.an_out,
                 want_a[i / SD], ~(4'b0001 << (i / SD)));
      end
    end
    do_load(16'h0000, 4'h0);
    wait_wrap();
    @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== want_b[i / SD] || bus.an_out !== ~(4'b0001 << (i / SD))) begin
        tests_failed++;
        $display("FAIL lzb_0000 i=%0d: seg=%h an=%h want %h %h", i, bus.seg_out, bus.an_out,
                 want_b[i / SD], ~(4'b0001 << (i / SD)));
      end
    end
    bus.lzb_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_wrap();
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    wait_wrap();
    @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== 7'h24) begin
        tests_failed++;
        $display("FAIL latest_load_wins i=%0d: seg=%h want 24", i, bus.seg_out);
      end
    end
    wait_wrap();
    do_load(16'h3333, 4'h0);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== 7'h30 || bus.an_out !== ~(4'b0001 << (i / SD))) begin
        tests_failed++;
        $display("FAIL load_on_wrap i=%0d: seg=%h an=%h want 30 %h", i, bus.seg_out, bus.an_out,
                 ~(4'b0001 << (i / SD)));
      end
    end
  endtask

  task automatic test_blank_mask();
    do_load(16'h8888, 4'b0100);
    wait_wrap();
    @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== ((i / SD) == 2 ? 7'h7F : 7'h00) || bus.an_out !== ~(4'b0001 << (i / SD))) begin
        tests_failed++;
        $display("FAIL blank_mask i=%0d: seg=%h an=%h want %h %h", i, bus.seg_out, bus.an_out,
                 ((i / SD) == 2 ? 7'h7F : 7'h00), ~(4'b0001 << (i / SD)));
      end
    end
  endtask

  task automatic test_blink();
    bit lit [8];
    bus.blink_mask = 4'b0001;
    do_load(16'h8888, 4'h0);
    wait_wrap();
    @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FR; i++) begin
        @(negedge clk);
        if (i == 1) lit[f] = (bus.seg_out !== 7'h7F);
        tests_run++;
        if (bus.seg_out !== exp_seg || bus.an_out !== exp_an || bus.frame_tick !== exp_ft) begin
          tests_failed++;
          $display("FAIL blink_model f=%0d i=%0d: seg=%h an=%h ft=%b want %h %h %b", f, i, bus.seg_out,
                   bus.an_out, bus.frame_tick, exp_seg, exp_an, exp_ft);
        end
      end
    end
    for (int f = 0; f < 6; f++) begin
      tests_run++;
`ifdef DISP_BLINK_EN
      if (lit[f] == lit[f + 2]) begin
        tests_failed++;
        $display("FAIL blink_alternate f=%0d: lit=%0d lit+2=%0d want different", f, lit[f], lit[f + 2]);
      end
`else
      if (!lit[f]) begin
        tests_failed++;
        $display("FAIL blink_ignored f=%0d: digit0 lit=%0d want 1", f, lit[f]);
      end
`endif
    end
    bus.blink_mask = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== exp_seg || bus.an_out !== exp_an || bus.frame_tick !== exp_ft) begin
        tests_failed++;
        $display("FAIL random i=%0d: seg=%h an=%h ft=%b want %h %h %b", i, bus.seg_out, bus.an_out,
                 bus.frame_tick, exp_seg, exp_an, exp_ft);
      end
      bus.load       = ($urandom_range(0, 5) == 0);
      bus.value_in   = 16'($urandom) >> $urandom_range(0, 16);
      bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 19) == 0) bus.lzb_en = ~bus.lzb_en;
      if ($urandom_range(0, 29) == 0) bus.blink_mask = 4'($urandom);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_load(16'h9ABC, 4'h0);
    wait_wrap();
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.seg_out !== 7'h7F || bus.an_out !== 4'hF || bus.frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: seg=%h an=%h ft=%b want 7f f 0", bus.seg_out, bus.an_out, bus.frame_tick);
    end
    bus.lzb_en = 1'b0;
    bus.blink_mask = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.seg_out !== 7'h40 || bus.an_out !== ~(4'b0001 << (i / SD)) ||
          bus.frame_tick !== (i == FR - 2)) begin
        tests_failed++;
        $display("FAIL reset_discard i=%0d: seg=%h an=%h ft=%b want 40 %h %b", i, bus.seg_out, bus.an_out,
                 bus.frame_tick, ~(4'b0001 << (i / SD)), (i == FR - 2));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_frame_update();
    test_lzb();
    test_back_to_back();
    test_blank_mask();
    test_blink();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
